// File: rtl/txbipcalc.sv
// Transmit-side B1 (BIP-8) and B2 (BIP-24, three interleaved byte lanes) calculator.
// Results and a frame-length error flag are published one cycle after each frame-closing txsof.
module txbipcalc #(
    parameter int unsigned FRMLEN = 2430
) (
    input  logic        clk19,
    input  logic        rst,
    input  logic        txsof,
    input  logic        en,
    input  logic [7:0]  sdat,
    input  logic [7:0]  udat,
    input  logic        rsoh,
    output logic [7:0]  b1dat,
    output logic        b1vld,
    output logic [23:0] b2dat,
    output logic        b2vld,
    output logic        frmerr
);

    logic [7:0]  b1acc_q, b1acc_d;
    logic [7:0]  lane0_q, lane0_d;
    logic [7:0]  lane1_q, lane1_d;
    logic [7:0]  lane2_q, lane2_d;
    logic [1:0]  phase_q, phase_d;
    logic [11:0] bcnt_q, bcnt_d;
    logic        armed_q, armed_d;
    logic [7:0]  b1dat_q, b1dat_d;
    logic [23:0] b2dat_q, b2dat_d;
    logic        b1vld_q, b1vld_d;
    logic        b2vld_q, b2vld_d;
    logic        frmerr_q, frmerr_d;

    always_comb begin
        b1acc_d  = b1acc_q;
        lane0_d  = lane0_q;
        lane1_d  = lane1_q;
        lane2_d  = lane2_q;
        phase_d  = phase_q;
        bcnt_d   = bcnt_q;
        armed_d  = armed_q;
        b1dat_d  = b1dat_q;
        b2dat_d  = b2dat_q;
        b1vld_d  = 1'b0;
        b2vld_d  = 1'b0;
        frmerr_d = 1'b0;

        if (txsof) begin
            // The first txsof after reset only arms; there is no complete frame to report yet.
            if (armed_q) begin
                b1dat_d  = b1acc_q;
                b2dat_d  = {lane0_q, lane1_q, lane2_q};
                b1vld_d  = 1'b1;
                b2vld_d  = 1'b1;
                frmerr_d = (32'(bcnt_q) != FRMLEN);
            end
            armed_d = 1'b1;
            // The txsof byte itself is byte 0 of the new frame.
            b1acc_d = en ? sdat : 8'h00;
            lane0_d = (en && !rsoh) ? udat : 8'h00;
            lane1_d = 8'h00;
            lane2_d = 8'h00;
            phase_d = en ? 2'd1 : 2'd0;
            bcnt_d  = en ? 12'd1 : 12'd0;
        end else if (en) begin
            b1acc_d = b1acc_q ^ sdat;
            if (!rsoh) begin
                case (phase_q)
                    2'd0:    lane0_d = lane0_q ^ udat;
                    2'd1:    lane1_d = lane1_q ^ udat;
                    2'd2:    lane2_d = lane2_q ^ udat;
                    default: ;
                endcase
            end
            phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
            if (bcnt_q != 12'hFFF) begin
                bcnt_d = bcnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk19) begin
        if (rst) begin
            b1acc_q  <= 8'h00;
            lane0_q  <= 8'h00;
            lane1_q  <= 8'h00;
            lane2_q  <= 8'h00;
            phase_q  <= 2'd0;
            bcnt_q   <= 12'd0;
            armed_q  <= 1'b0;
            b1dat_q  <= 8'h00;
            b2dat_q  <= 24'h000000;
            b1vld_q  <= 1'b0;
            b2vld_q  <= 1'b0;
            frmerr_q <= 1'b0;
        end else begin
            b1acc_q  <= b1acc_d;
            lane0_q  <= lane0_d;
            lane1_q  <= lane1_d;
            lane2_q  <= lane2_d;
            phase_q  <= phase_d;
            bcnt_q   <= bcnt_d;
            armed_q  <= armed_d;
            b1dat_q  <= b1dat_d;
            b2dat_q  <= b2dat_d;
            b1vld_q  <= b1vld_d;
            b2vld_q  <= b2vld_d;
            frmerr_q <= frmerr_d;
        end
    end

    assign b1dat  = b1dat_q;
    assign b2dat  = b2dat_q;
    assign b1vld  = b1vld_q;
    assign b2vld  = b2vld_q;
    assign frmerr = frmerr_q;

endmodule

// File: tb/tb_txbipcalc.sv
// Bench for txbipcalc (FRMLEN=9): reference model feeds a scoreboard of expected frame results,
// plus hand-computed constant checks on the directed frames.
module tb_txbipcalc;

    localparam int unsigned FrmLen = 9;

    logic        clk19 = 1'b0;
    logic        rst = 1'b0;
    logic        txsof = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  sdat = 8'h00;
    logic [7:0]  udat = 8'h00;
    logic        rsoh = 1'b0;
    logic [7:0]  b1dat;
    logic        b1vld;
    logic [23:0] b2dat;
    logic        b2vld;
    logic        frmerr;

    txbipcalc #(.FRMLEN(FrmLen)) dut (
        .clk19  (clk19),
        .rst    (rst),
        .txsof  (txsof),
        .en     (en),
        .sdat   (sdat),
        .udat   (udat),
        .rsoh   (rsoh),
        .b1dat  (b1dat),
        .b1vld  (b1vld),
        .b2dat  (b2dat),
        .b2vld  (b2vld),
        .frmerr (frmerr)
    );

    always #5 clk19 = ~clk19;

    typedef struct packed {
        logic [7:0]  b1;
        logic [23:0] b2;
        logic        fe;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model state
    logic [7:0] m_b1;
    logic [7:0] m_ln [3];
    int         m_ph;
    int         m_cnt;
    logic       m_armed;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_b1 = 8'h00;
        m_ln[0] = 8'h00;
        m_ln[1] = 8'h00;
        m_ln[2] = 8'h00;
        m_ph = 0;
        m_cnt = 0;
        m_armed = 1'b0;
    endtask

    // Drive one byte slot, advance the model, push any expected report, clock once.
    task automatic drive(input logic sof, input logic e, input logic [7:0] s,
                         input logic [7:0] u, input logic r);
        exp_t x;
        txsof = sof;
        en = e;
        sdat = s;
        udat = u;
        rsoh = r;
        if (sof) begin
            if (m_armed) begin
                x.b1 = m_b1;
                x.b2 = {m_ln[0], m_ln[1], m_ln[2]};
                x.fe = (m_cnt != FrmLen);
                sb_q.push_back(x);
            end
            m_armed = 1'b1;
            m_b1 = e ? s : 8'h00;
            m_ln[0] = (e && !r) ? u : 8'h00;
            m_ln[1] = 8'h00;
            m_ln[2] = 8'h00;
            m_ph = e ? 1 : 0;
            m_cnt = e ? 1 : 0;
        end else if (e) begin
            m_b1 = m_b1 ^ s;
            if (!r) m_ln[m_ph] = m_ln[m_ph] ^ u;
            m_ph = (m_ph + 1) % 3;
            if (m_cnt < 4095) m_cnt++;
        end
        @(posedge clk19);
        #1;
        txsof = 1'b0;
        en = 1'b0;
        rsoh = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        @(posedge clk19);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [7:0] b1,
                             input logic [23:0] b2, input logic fe);
        check({tag, ".b1vld"}, 32'(b1vld), 32'(vld));
        check({tag, ".b2vld"}, 32'(b2vld), 32'(vld));
        check({tag, ".frmerr"}, 32'(frmerr), 32'(fe));
        check({tag, ".b1dat"}, 32'(b1dat), 32'(b1));
        check({tag, ".b2dat"}, 32'(b2dat), 32'(b2));
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk19) begin
        exp_t x;
        if (b1vld !== b2vld) check("vld_pair", 32'(b2vld), 32'(b1vld));
        if (frmerr === 1'b1 && b1vld !== 1'b1) check("frmerr_alone", 32'(frmerr), 32'd0);
        if (b1vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 32'(b1vld), 32'd0);
            end else begin
                x = sb_q.pop_front();
                check("sb.b1dat", 32'(b1dat), 32'(x.b1));
                check("sb.b2dat", 32'(b2dat), 32'(x.b2));
                check("sb.frmerr", 32'(frmerr), 32'(x.fe));
            end
        end
    end

    initial begin
        model_clear();
        do_reset();
        check_out("reset", 1'b0, 8'h00, 24'h000000, 1'b0);

        // Frame A: 9 bytes of 0x01; the first txsof only arms
        drive(1'b1, 1'b1, 8'h01, 8'h01, 1'b0);
        check_out("first_sof", 1'b0, 8'h00, 24'h000000, 1'b0);
        for (int i = 1; i < 9; i++) drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);

        // Frame B: same data, RSOH on bytes 0-2; its txsof closes A
        drive(1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
        check_out("frame_a", 1'b1, 8'h01, 24'h010101, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_out("hold_a", 1'b0, 8'h01, 24'h010101, 1'b0);
        for (int i = 1; i < 9; i++) drive(1'b0, 1'b1, 8'h01, 8'h01, i < 3);

        // Frame C: udat 11,22,44 repeated, sdat FF
        drive(1'b1, 1'b1, 8'hFF, 8'h11, 1'b0);
        check_out("frame_b", 1'b1, 8'h01, 24'h000000, 1'b0);
        for (int i = 1; i < 9; i++) begin
            logic [7:0] u;
            u = (i % 3 == 0) ? 8'h11 : ((i % 3 == 1) ? 8'h22 : 8'h44);
            drive(1'b0, 1'b1, 8'hFF, u, 1'b0);
        end

        // Frame D: 8 qualified bytes with idle slots between, one bit each of sdat
        drive(1'b1, 1'b1, 8'h01, 8'h05, 1'b0);
        check_out("frame_c", 1'b1, 8'hFF, 24'h112244, 1'b0);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 1'b0, 8'hAA, 8'hAA, 1'b0);
            drive(1'b0, 1'b1, 8'h01 << i, 8'(i * 37), 1'b0);
        end

        // Back-to-back txsof: frames of length 1 and 0
        drive(1'b1, 1'b1, 8'h33, 8'h44, 1'b0);
        check("frame_d.b1dat", 32'(b1dat), 32'h0000_00FF);
        check("frame_d.frmerr", 32'(frmerr), 32'd1);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        check_out("len1", 1'b1, 8'h33, 24'h440000, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        check_out("len0", 1'b1, 8'h00, 24'h000000, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_out("hold_len0", 1'b0, 8'h00, 24'h000000, 1'b0);

        // Partial frame discarded by reset, then a clean frame
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h77, 8'h99, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        do_reset();
        check_out("mid_reset", 1'b0, 8'h00, 24'h000000, 1'b0);
        drive(1'b1, 1'b1, 8'h5A, 8'h0F, 1'b0);
        check_out("rearm_sof", 1'b0, 8'h00, 24'h000000, 1'b0);
        for (int i = 1; i < 9; i++) drive(1'b0, 1'b1, 8'h5A, 8'h0F, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        check_out("after_reset", 1'b1, 8'h5A, 24'h0F0F0F, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("one_cycle_strobe", 32'(b1vld), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/txbipcalc.md
TXBIPCALC -- requirements
Module: txbipcalc

Interface
REQ-001 Parameter FRMLEN, default 2430, meaning: expected count of en-qualified bytes per frame.
REQ-002 clk19  input  1  byte clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 txsof  input  1  start of frame; marks the first byte slot of a new frame.
REQ-005 en  input  1  byte qualifier; sdat/udat/rsoh are sampled only when en=1.
REQ-006 sdat  input  8  scrambled transmit byte, covered by B1.
REQ-007 udat  input  8  unscrambled transmit byte, covered by B2.
REQ-008 rsoh  input  1  current byte is RSOH and is excluded from B2.
REQ-009 b1dat  output  8  BIP-8 of the previous complete frame.
REQ-010 b1vld  output  1  one-cycle strobe; b1dat updated.
REQ-011 b2dat  output  24  BIP-24 of the previous frame; lane0=[23:16], lane1=[15:8], lane2=[7:0].
REQ-012 b2vld  output  1  one-cycle strobe; b2dat updated.
REQ-013 frmerr  output  1  one-cycle strobe with b1vld; previous frame length differed from FRMLEN.

Function
REQ-014 b1acc(8) SHALL XOR every sdat with en=1; bytes with en=0 are ignored.
REQ-015 Lane phase counter (0..2) SHALL advance on every en=1 byte, RSOH bytes included, wrapping 2->0.
REQ-016 Lane accumulators: lane[phase] ^= udat when en=1 and rsoh=0; with rsoh=1 the phase advances and no lane changes.
REQ-017 Byte counter bcnt (12 bit) SHALL increment on en=1 and saturate at 4095.
REQ-018 armed flag SHALL be 0 after reset and set by the first txsof.
REQ-019 On the edge with txsof=1 and armed=1: b1dat<=b1acc, b2dat<={lane0,lane1,lane2}, b1vld/b2vld<=1 for the next cycle only, frmerr<=(bcnt!=FRMLEN).
REQ-020 On the edge with txsof=1 and armed=0: no strobes, and b1dat/b2dat hold.
REQ-021 On every txsof edge, accumulators restart with the txsof byte as frame byte 0: b1acc<=(en?sdat:0), lane0<=(en&!rsoh?udat:0), lane1/lane2<=0, phase<=(en?1:0), bcnt<=(en?1:0).
REQ-022 Latency: strobes are asserted exactly one cycle after the txsof cycle.
REQ-023 b1dat/b2dat SHALL hold between strobes.
REQ-024 If txsof repeats on consecutive cycles, each txsof closes a frame; lengths 0 or 1 raise frmerr.
REQ-025 Strobes SHALL never be asserted for more than one cycle per txsof.

Reset
REQ-026 rst=1 SHALL clear b1dat, b2dat, b1vld, b2vld, frmerr, all accumulators, phase, bcnt and armed on the same edge, overriding txsof.
REQ-027 A reset mid-frame SHALL discard the partial frame; the next txsof only arms the block.

Verification (bench FRMLEN=9)
REQ-028 Reset, txsof, 9 bytes sdat=udat=0x01, rsoh=0, then txsof -> one cycle later b1vld=b2vld=1, b1dat=0x01, b2dat=0x010101, frmerr=0.
REQ-029 Same frame with rsoh=1 on bytes 0-2 -> b1dat=0x01, b2dat=0x000000.
REQ-030 Bytes udat=0x11,0x22,0x44 repeated 3x, rsoh=0, sdat=0xFF -> b2dat=0x112244, b1dat=0xFF.
REQ-031 Frame of 8 bytes, en low on alternate cycles -> frmerr=1 with b1vld, b1dat=XOR of the 8 bytes.
REQ-032 First txsof after reset -> no b1vld/b2vld/frmerr; outputs stay 0x00/0x000000.
REQ-033 rst pulsed mid-frame, then txsof, 9 bytes, txsof -> no strobe at the first txsof; a normal strobe with correct BIP values at the second.
